// File: rtl/pwm_capture_pkg.sv
// Shared constants for the PWM capture peripheral: FSM encodings,
// register offsets (address[4:2]) and CTRL/STATUS bit positions.
package pwm_capture_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEAS_HI = 2'd1;
    localparam logic [1:0] ST_MEAS_LO = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    // Register offsets, decoded from address[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PERIOD = 3'd1;
    localparam logic [2:0] REG_HIGH   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;

    // CTRL bit positions
    localparam int unsigned CTRL_W       = 7;
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_POL     = 1;
    localparam int unsigned CTRL_INTE    = 2;
    localparam int unsigned CTRL_SINGLE  = 3;
    localparam int unsigned CTRL_SEL_LSB = 4;
    localparam int unsigned SEL_W        = 3;

    // STATUS bit positions
    localparam int unsigned STATUS_W    = 3;
    localparam int unsigned STAT_VALID  = 0;
    localparam int unsigned STAT_INT    = 1;
    localparam int unsigned STAT_OVF    = 2;

endpackage

// File: rtl/pwm_cap_edge.sv
// Input conditioning for the PWM capture: selects one ui_in pin, applies
// the polarity inversion, samples twice and produces rise/fall pulses.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ui_in         synchronised input pins
//   sel, pol      pin select and polarity invert
//   sig_q         conditioned, registered level
//   rise_c/fall_c single-cycle edge pulses (combinational from flops)
module pwm_cap_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    input  logic [2:0] sel,
    input  logic       pol,
    output logic       sig_q,
    output logic       rise_c,
    output logic       fall_c
);

    logic sig_d;
    logic sig_qq;

    always_comb begin
        sig_d = ui_in[sel] ^ pol;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q  <= 1'b0;
            sig_qq <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            sig_qq <= sig_q;
        end
    end

    assign rise_c = sig_q & ~sig_qq;
    assign fall_c = ~sig_q & sig_qq;

endmodule

// File: rtl/tqvp_pwm_capture.sv
// TinyQV peripheral measuring period and high time of a PWM input pin.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ui_in                    synchronised input PMOD
//   uo_out                   [7]=VALID, [6]=conditioned input, rest 0
//   address/data_in          register offset and write data
//   data_write_n/data_read_n bus strobes (2'b11 = idle)
//   data_out/data_ready      read data and zero-wait acknowledge
//   user_interrupt           STATUS.INT & CTRL.INTE
module tqvp_pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CW = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    logic [CTRL_W-1:0]   ctrl_q,   ctrl_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic [1:0]          state_q,  state_d;
    logic [CW-1:0]       cnt_q,    cnt_d;
    logic [CW-1:0]       hi_lat_q, hi_lat_d;
    logic [CW-1:0]       period_q, period_d;
    logic [CW-1:0]       high_q,   high_d;

    logic [2:0]  reg_sel;
    logic        wr_c;
    logic        ctrl_wr;
    logic        status_wr;
    logic        sig_q;
    logic        rise_c;
    logic        fall_c;
    logic [CW-1:0] cnt_inc;
    logic [31:0] rdata;
    logic        unused_bits;

    assign reg_sel     = address[4:2];
    assign wr_c        = (data_write_n != 2'b11);
    assign ctrl_wr     = wr_c && (reg_sel == REG_CTRL);
    assign status_wr   = wr_c && (reg_sel == REG_STATUS);
    assign unused_bits = ^{address[5], address[1:0], data_in[31:CTRL_W]};

    pwm_cap_edge u_edge (
        .clk    (clk),
        .rst    (rst),
        .ui_in  (ui_in),
        .sel    (ctrl_q[CTRL_SEL_LSB +: SEL_W]),
        .pol    (ctrl_q[CTRL_POL]),
        .sig_q  (sig_q),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Saturating counter increment
    always_comb begin
        cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    end

    // Next-state, counter, result and status logic
    always_comb begin
        ctrl_d   = ctrl_wr ? data_in[CTRL_W-1:0] : ctrl_q;
        status_d = status_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_lat_d = hi_lat_q;
        period_d = period_q;
        high_d   = high_q;

        // W1C applied first so that hardware sets below take priority
        if (status_wr) begin
            status_d = status_q & ~data_in[STATUS_W-1:0];
        end

        if (ctrl_wr) begin
            // A CTRL write restarts capture and discards any edge this cycle;
            // HOLD is only kept while the write leaves EN=1 and SINGLE=1.
            if (!(state_q == ST_HOLD && data_in[CTRL_EN] && data_in[CTRL_SINGLE])) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else if (!ctrl_q[CTRL_EN]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (cnt_q == {CW{1'b1}}) begin
            status_d[STAT_OVF] = 1'b1;
            state_d            = ST_IDLE;
            cnt_d              = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise_c) begin
                        state_d = ST_MEAS_HI;
                        cnt_d   = CW'(1);
                    end
                end
                ST_MEAS_HI: begin
                    if (rise_c) begin
                        cnt_d = CW'(1);
                    end else if (fall_c) begin
                        hi_lat_d = cnt_q;
                        cnt_d    = cnt_inc;
                        state_d  = ST_MEAS_LO;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_MEAS_LO: begin
                    if (rise_c) begin
                        period_d             = cnt_q;
                        high_d               = hi_lat_q;
                        status_d[STAT_VALID] = 1'b1;
                        if (ctrl_q[CTRL_INTE]) begin
                            status_d[STAT_INT] = 1'b1;
                        end
                        cnt_d   = CW'(1);
                        state_d = ctrl_q[CTRL_SINGLE] ? ST_HOLD : ST_MEAS_HI;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            status_q <= '0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_lat_q <= '0;
            period_q <= '0;
            high_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_lat_q <= hi_lat_d;
            period_q <= period_d;
            high_q   <= high_d;
        end
    end

    // Read mux
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL:   rdata = 32'(ctrl_q);
            REG_PERIOD: rdata = 32'(period_q);
            REG_HIGH:   rdata = 32'(high_q);
            REG_STATUS: rdata = 32'(status_q);
            default:    rdata = '0;
        endcase
    end

    assign data_ready     = (data_read_n != 2'b11);
    assign data_out       = data_ready ? rdata : 32'd0;
    assign uo_out         = {status_q[STAT_VALID], sig_q, 6'b0};
    assign user_interrupt = status_q[STAT_INT] & ctrl_q[CTRL_INTE];

endmodule
